// File: rtl/fmul_norm_round.sv
// FloatMul post-adder stage: normalise, round (RNE with FMUL_NR_RNE_EN, else truncate), clamp exponent.
// Latency 2 cycles (S1 normalise, S2 round/clamp), throughput 1/cycle.
// Valid/ready backpressure; in_ready is combinational from downstream ready, so there is no bubble.
module fmul_norm_round #(
  parameter int EXP_W = 8,
  parameter int SUM_W = 23
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SUM_W-1:0]        in_sum,
  input  logic signed [EXP_W+1:0] in_exp,
  input  logic                    in_sign,
  input  logic                    in_sticky,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sign,
  output logic [EXP_W-1:0]        out_exp,
  output logic [SUM_W-4:0]        out_frac,
  output logic                    out_ovf,
  output logic                    out_unf
);

  localparam int FRAC_W = SUM_W - 3;
  localparam int E_W    = EXP_W + 3;  // headroom for +1 normalise and +1 rounding carry

`ifdef FMUL_NR_RNE_EN
  localparam logic RNE_EN = 1'b1;
`else
  localparam logic RNE_EN = 1'b0;
`endif

  typedef struct packed {
    logic              sign;
    logic              zero;
    logic              g;
    logic              s;
    logic [FRAC_W-1:0] frac;
    logic [E_W-1:0]    e;
  } s1_t;

  s1_t  s1_d, s1_q;
  logic s1_v;
  logic s1_adv, s2_adv;

  assign s2_adv   = !out_valid | out_ready;
  assign s1_adv   = !s1_v | s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    s1_d      = '0;
    s1_d.sign = in_sign;
    s1_d.zero = (in_sum == '0);
    s1_d.e    = {in_exp[EXP_W+1], in_exp} + {{(E_W-1){1'b0}}, in_sum[SUM_W-1]};
    if (in_sum[SUM_W-1]) begin
      s1_d.frac = in_sum[SUM_W-2:2];
      s1_d.g    = in_sum[1];
      s1_d.s    = in_sum[0] | in_sticky;
    end else begin
      s1_d.frac = in_sum[SUM_W-3:1];
      s1_d.g    = in_sum[0];
      s1_d.s    = in_sticky;
    end
  end

  logic              inc;
  logic [FRAC_W:0]   frac_rnd;
  logic [E_W-1:0]    e_rnd;
  logic              e_nonpos, e_big;
  logic [EXP_W-1:0]  exp_d;
  logic [FRAC_W-1:0] frac_d;
  logic              ovf_d, unf_d;

  always_comb begin
    inc      = RNE_EN & s1_q.g & (s1_q.s | s1_q.frac[0]);
    frac_rnd = {1'b0, s1_q.frac} + {{FRAC_W{1'b0}}, inc};
    // A rounding carry leaves the low bits at zero, so only the exponent moves.
    e_rnd    = s1_q.e + {{(E_W-1){1'b0}}, frac_rnd[FRAC_W]};
    e_nonpos = e_rnd[E_W-1] | (e_rnd == '0);
    e_big    = !e_rnd[E_W-1] && (e_rnd[E_W-2:0] >= (E_W-1)'((2**EXP_W) - 1));
    exp_d    = e_rnd[EXP_W-1:0];
    frac_d   = frac_rnd[FRAC_W-1:0];
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    if (s1_q.zero) begin
      exp_d  = '0;
      frac_d = '0;
    end else if (e_big) begin
      exp_d  = '1;
      frac_d = '0;
      ovf_d  = 1'b1;
    end else if (e_nonpos) begin
      exp_d  = '0;
      frac_d = '0;
      unf_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s1_q      <= '0;
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_exp   <= '0;
      out_frac  <= '0;
      out_ovf   <= 1'b0;
      out_unf   <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_v <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_adv) begin
        out_valid <= s1_v;
        if (s1_v) begin
          out_sign <= s1_q.sign;
          out_exp  <= exp_d;
          out_frac <= frac_d;
          out_ovf  <= ovf_d;
          out_unf  <= unf_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_fmul_norm_round.sv
// Directed and randomised checks of fmul_norm_round; expectations follow FMUL_NR_RNE_EN.
module tb_fmul_norm_round;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b1;
  logic               in_ready;
  logic [22:0]        in_sum = 23'h400000;
  logic signed [9:0]  in_exp = 10'sd10;
  logic               in_sign = 1'b0;
  logic               in_sticky = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic               out_sign;
  logic [7:0]         out_exp;
  logic [19:0]        out_frac;
  logic               out_ovf;
  logic               out_unf;
  logic [30:0]        res;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fmul_norm_round dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_exp(in_exp), .in_sign(in_sign), .in_sticky(in_sticky),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_frac(out_frac),
    .out_ovf(out_ovf), .out_unf(out_unf)
  );

  assign res = {out_sign, out_exp, out_frac, out_ovf, out_unf};

  function automatic logic [30:0] mk(input logic sg, input logic [7:0] ex,
                                     input logic [19:0] fr, input logic ov, input logic un);
    return {sg, ex, fr, ov, un};
  endfunction

  task automatic chk(input string tag, input logic [30:0] obs, input logic [30:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Reference: keep the top 21 significant bits, round on the dropped remainder.
  function automatic logic [30:0] model(input logic [22:0] s, input logic signed [9:0] ein,
                                        input logic sg, input logic st);
    int e, sh;
    int unsigned q, rem, half;
    logic up;
    if (s == 23'd0) return mk(sg, 8'd0, 20'd0, 1'b0, 1'b0);
    sh   = s[22] ? 2 : 1;
    e    = int'(ein) + (s[22] ? 1 : 0);
    q    = 32'(s) >> sh;
    rem  = 32'(s) & ((32'd1 << sh) - 32'd1);
    half = 32'd1 << (sh - 1);
    up   = (rem > half) || ((rem == half) && (st || q[0]));
`ifndef FMUL_NR_RNE_EN
    up = 1'b0;
`endif
    q = q + {31'd0, up};
    if (q >= 32'h200000) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return mk(sg, 8'hFF, 20'd0, 1'b1, 1'b0);
    if (e <= 0)   return mk(sg, 8'd0, 20'd0, 1'b0, 1'b1);
    return mk(sg, 8'(e), 20'(q), 1'b0, 1'b0);
  endfunction

  task automatic vec(input string tag, input logic [22:0] s, input logic signed [9:0] e,
                     input logic sg, input logic st, input logic [30:0] expv);
    @(negedge clk);
    in_sum = s; in_exp = e; in_sign = sg; in_sticky = st;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk1({tag, "_lat1"}, out_valid, 1'b0);
    @(negedge clk);
    chk1({tag, "_vld"}, out_valid, 1'b1);
    chk({tag, "_res"}, res, expv);
  endtask

  logic [30:0] snap;
  logic [30:0] sbq[$];
  int sent, got;
  bit pend;

  initial begin
    // Reset held with in_valid high
    repeat (3) begin
      @(negedge clk);
      chk1("rst_out_valid", out_valid, 1'b0);
    end
    chk("rst_out_regs", res, 31'd0);
    chk1("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk1("post_rst_no_out", out_valid, 1'b0);
    end

    // Reset mid-flight discards the in-pipe item
    @(negedge clk);
    in_sum = 23'h200000; in_exp = 10'sd10; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk1("midrst_out0", out_valid, 1'b0);
    @(negedge clk);
    chk1("midrst_out1", out_valid, 1'b0);

    vec("norm_lo",   23'h200000, 10'sd10,  1'b0, 1'b0, mk(1'b0, 8'd10, 20'd0, 1'b0, 1'b0));
    vec("norm_hi",   23'h400000, 10'sd10,  1'b0, 1'b0, mk(1'b0, 8'd11, 20'd0, 1'b0, 1'b0));
    vec("tie_even",  23'h200001, 10'sd10,  1'b0, 1'b0, mk(1'b0, 8'd10, 20'd0, 1'b0, 1'b0));
`ifdef FMUL_NR_RNE_EN
    vec("tie_odd",   23'h200003, 10'sd10,  1'b0, 1'b0, mk(1'b0, 8'd10, 20'h00002, 1'b0, 1'b0));
    vec("carry",     23'h3FFFFF, 10'sd10,  1'b0, 1'b0, mk(1'b0, 8'd11, 20'd0, 1'b0, 1'b0));
    vec("sticky_hi", 23'h400002, 10'sd10,  1'b0, 1'b1, mk(1'b0, 8'd11, 20'h00001, 1'b0, 1'b0));
    vec("carry_ovf", 23'h3FFFFF, 10'sd254, 1'b0, 1'b0, mk(1'b0, 8'hFF, 20'd0, 1'b1, 1'b0));
`else
    vec("tie_odd",   23'h200003, 10'sd10,  1'b0, 1'b0, mk(1'b0, 8'd10, 20'h00001, 1'b0, 1'b0));
    vec("carry",     23'h3FFFFF, 10'sd10,  1'b0, 1'b0, mk(1'b0, 8'd10, 20'hFFFFF, 1'b0, 1'b0));
    vec("sticky_hi", 23'h400002, 10'sd10,  1'b0, 1'b1, mk(1'b0, 8'd11, 20'h00000, 1'b0, 1'b0));
    vec("carry_ovf", 23'h3FFFFF, 10'sd254, 1'b0, 1'b0, mk(1'b0, 8'd254, 20'hFFFFF, 1'b0, 1'b0));
`endif
    vec("ovf",       23'h400000, 10'sd254, 1'b0, 1'b0, mk(1'b0, 8'hFF, 20'd0, 1'b1, 1'b0));
    vec("max_norm",  23'h200000, 10'sd254, 1'b1, 1'b0, mk(1'b1, 8'd254, 20'd0, 1'b0, 1'b0));
    vec("min_norm",  23'h200000, 10'sd1,   1'b0, 1'b0, mk(1'b0, 8'd1, 20'd0, 1'b0, 1'b0));
    vec("unf_zero",  23'h200000, 10'sd0,   1'b0, 1'b0, mk(1'b0, 8'd0, 20'd0, 1'b0, 1'b1));
    vec("unf_neg",   23'h200000, -10'sd3,  1'b1, 1'b0, mk(1'b1, 8'd0, 20'd0, 1'b0, 1'b1));
    vec("unf_hi",    23'h400000, -10'sd1,  1'b0, 1'b0, mk(1'b0, 8'd0, 20'd0, 1'b0, 1'b1));
    vec("zero",      23'h000000, 10'sd100, 1'b1, 1'b1, mk(1'b1, 8'd0, 20'd0, 1'b0, 1'b0));

    // Backpressure: 4 back-to-back inputs, downstream stalled for 5 cycles
    sent = 0; got = 0; snap = '0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      @(negedge clk);
      out_ready = (c >= 5);
      if (sent < 4) begin
        in_valid = 1'b1;
        in_sum   = 23'h200000 | 23'(sent * 2);
        in_exp   = 10'(20 + sent);
        in_sign  = 1'b0; in_sticky = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c == 2) begin
        chk1("bp_in_ready_drop", in_ready, 1'b0);
        snap = res;
      end
      if (c == 3 || c == 4) begin
        chk1("bp_stall_vld", out_valid, 1'b1);
        chk("bp_stall_stable", res, snap);
      end
      if (out_valid && out_ready) begin
        chk($sformatf("bp_out%0d", got), res, mk(1'b0, 8'(20 + got), 20'(got), 1'b0, 1'b0));
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    chk1("bp_count", got == 4, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk1("bp_no_dup", out_valid, 1'b0);

    // Random traffic against the reference model
    pend = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (!pend) begin
        in_valid = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) begin
          in_sum = 23'd0;
        end else begin
          in_sum = 23'($urandom);
          if (!in_sum[22]) in_sum[21] = 1'b1;
        end
        in_exp    = 10'(int'($urandom_range(0, 300)) - 20);
        in_sign   = 1'($urandom);
        in_sticky = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) chk1("rnd_spurious", out_valid, 1'b0);
        else chk("rnd_res", res, sbq.pop_front());
      end
      pend = in_valid && !in_ready;
      if (in_valid && in_ready) sbq.push_back(model(in_sum, in_exp, in_sign, in_sticky));
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid && sbq.size() != 0) chk("rnd_drain", res, sbq.pop_front());
      @(negedge clk);
    end
    chk1("rnd_all_out", sbq.size() == 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
